// File: rtl/contador_pkg.sv
// Shared constants for the contador_4bits counter slice.
`timescale 1ns/1ps
package contador_pkg;

  localparam int unsigned CNT_WIDTH = 4;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;

endpackage

// File: rtl/flipflop_t.sv
// Single-bit T flip-flop with async active-low clear and set; clear wins.
`timescale 1ns/1ps
module flipflop_t (
  input  logic clock,
  input  logic t,
  input  logic reset,
  input  logic preset,
  output logic q
);

  logic set_n;

  // Set is qualified by reset so that releasing reset while preset is still low
  // produces a falling edge on set_n and loads ones asynchronously.
  always_comb set_n = preset | ~reset;

  always_ff @(posedge clock or negedge reset or negedge set_n) begin
    if (!reset) begin
      q <= 1'b0;
    end else if (!set_n) begin
      q <= 1'b1;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/contador_4bits.sv
// Synchronous binary up-counter built from toggle flip-flops and an AND chain.
`timescale 1ns/1ps
module contador_4bits
  import contador_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             preset,
  output logic [WIDTH-1:0] Q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic t;

    // Bit i toggles only when every lower bit is already one.
    if (i == 0) begin : g_lsb
      always_comb t = 1'b1;
    end else begin : g_upper
      always_comb t = &Q[i-1:0];
    end

    flipflop_t u_ff (
      .clock  (clock),
      .t      (t),
      .reset  (reset),
      .preset (preset),
      .q      (Q[i])
    );
  end

endmodule

// File: tb/tb_contador_4bits.sv
// Self-checking bench for contador_4bits: directed scenarios plus randomized async pulses.
`timescale 1ns/1ps
module tb_contador_4bits;
  import contador_pkg::*;

  logic                 clock  = 1'b1;
  logic                 reset  = 1'b1;
  logic                 preset = 1'b1;
  logic [CNT_WIDTH-1:0] Q;

  int tests_run = 0;
  int tests_failed = 0;
  int model_q = 0;
  logic [CNT_WIDTH-1:0] expect_q;

  contador_4bits #(.WIDTH(CNT_WIDTH)) dut (
    .clock  (clock),
    .reset  (reset),
    .preset (preset),
    .Q      (Q)
  );

  always #25 clock = ~clock;

  // Reference model: integer count modulo 2^WIDTH, overridden by the async controls.
  always @(posedge clock) begin
    if (reset && preset) model_q = (model_q + 1) % (1 << CNT_WIDTH);
  end

  always @(reset or preset) begin
    if (!reset) model_q = 0;
    else if (!preset) model_q = (1 << CNT_WIDTH) - 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

  task automatic test_reset;
    #1 reset = 1'b0;
    #20;
    tests_run++;
    if (Q !== CNT_ZERO) begin
      tests_failed++;
      $display("FAIL reset_no_edge: Q=%b expected=%b", Q, CNT_ZERO);
    end
    @(negedge clock);
    #5 reset = 1'b1;
    #1;
    tests_run++;
    if (Q !== CNT_ZERO) begin
      tests_failed++;
      $display("FAIL reset_release_hold: Q=%b expected=%b", Q, CNT_ZERO);
    end
  endtask

  task automatic test_count_wrap;
    logic [CNT_WIDTH-1:0] exp_v;
    for (int k = 1; k <= 16; k++) begin
      exp_v = CNT_WIDTH'(k % 16);
      @(posedge clock);
      #1;
      tests_run++;
      if (Q !== exp_v) begin
        tests_failed++;
        $display("FAIL count_rise step=%0d: Q=%b expected=%b", k, Q, exp_v);
      end
      @(negedge clock);
      #1;
      tests_run++;
      if (Q !== exp_v) begin
        tests_failed++;
        $display("FAIL count_fall step=%0d: Q=%b expected=%b", k, Q, exp_v);
      end
    end
  endtask

  task automatic test_preset;
    repeat (5) @(posedge clock);
    #1;
    tests_run++;
    if (Q !== 4'b0101) begin
      tests_failed++;
      $display("FAIL preset_setup: Q=%b expected=0101", Q);
    end
    @(negedge clock);
    #5 preset = 1'b0;
    #1;
    tests_run++;
    if (Q !== CNT_ONES) begin
      tests_failed++;
      $display("FAIL preset_async: Q=%b expected=%b", Q, CNT_ONES);
    end
    #5 preset = 1'b1;
    #1;
    tests_run++;
    if (Q !== CNT_ONES) begin
      tests_failed++;
      $display("FAIL preset_release_hold: Q=%b expected=%b", Q, CNT_ONES);
    end
    @(posedge clock);
    #1;
    tests_run++;
    if (Q !== CNT_ZERO) begin
      tests_failed++;
      $display("FAIL preset_wrap: Q=%b expected=%b", Q, CNT_ZERO);
    end
  endtask

  task automatic test_reset_mid_count;
    repeat (10) @(posedge clock);
    #1;
    tests_run++;
    if (Q !== 4'b1010) begin
      tests_failed++;
      $display("FAIL midreset_setup: Q=%b expected=1010", Q);
    end
    @(negedge clock);
    #5 reset = 1'b0;
    #1;
    tests_run++;
    if (Q !== CNT_ZERO) begin
      tests_failed++;
      $display("FAIL midreset_async: Q=%b expected=%b", Q, CNT_ZERO);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      tests_run++;
      if (Q !== CNT_ZERO) begin
        tests_failed++;
        $display("FAIL midreset_hold edge=%0d: Q=%b expected=%b", k, Q, CNT_ZERO);
      end
    end
    @(negedge clock);
    #5 reset = 1'b1;
    @(posedge clock);
    #1;
    tests_run++;
    if (Q !== 4'b0001) begin
      tests_failed++;
      $display("FAIL midreset_resume: Q=%b expected=0001", Q);
    end
  endtask

  task automatic test_both_low;
    @(negedge clock);
    #5;
    reset = 1'b0;
    preset = 1'b0;
    #1;
    tests_run++;
    if (Q !== CNT_ZERO) begin
      tests_failed++;
      $display("FAIL both_low: Q=%b expected=%b", Q, CNT_ZERO);
    end
    #5 reset = 1'b1;
    #1;
    tests_run++;
    if (Q !== CNT_ONES) begin
      tests_failed++;
      $display("FAIL both_release_reset: Q=%b expected=%b", Q, CNT_ONES);
    end
    #5 preset = 1'b1;
    #1;
    tests_run++;
    if (Q !== CNT_ONES) begin
      tests_failed++;
      $display("FAIL both_release_preset: Q=%b expected=%b", Q, CNT_ONES);
    end
    @(posedge clock);
    #1;
    tests_run++;
    if (Q !== CNT_ZERO) begin
      tests_failed++;
      $display("FAIL both_wrap: Q=%b expected=%b", Q, CNT_ZERO);
    end
  endtask

  task automatic test_random;
    int unsigned sel;
    for (int n = 0; n < 64; n++) begin
      @(negedge clock);
      #2;
      sel = $urandom_range(0, 7);
      if (sel <= 2) begin
        if (sel == 0) reset = 1'b0;
        else if (sel == 1) preset = 1'b0;
        else begin
          reset = 1'b0;
          preset = 1'b0;
        end
        #3;
        expect_q = model_q[CNT_WIDTH-1:0];
        tests_run++;
        if (Q !== expect_q) begin
          tests_failed++;
          $display("FAIL rand_pulse iter=%0d sel=%0d: Q=%b expected=%b", n, sel, Q, expect_q);
        end
        if (sel == 2 && $urandom_range(0, 1) == 1) begin
          preset = 1'b1;
          #2;
          reset = 1'b1;
        end else begin
          reset = 1'b1;
          #2;
          preset = 1'b1;
        end
        #1;
        expect_q = model_q[CNT_WIDTH-1:0];
        tests_run++;
        if (Q !== expect_q) begin
          tests_failed++;
          $display("FAIL rand_release iter=%0d sel=%0d: Q=%b expected=%b", n, sel, Q, expect_q);
        end
      end
      @(posedge clock);
      #1;
      expect_q = model_q[CNT_WIDTH-1:0];
      tests_run++;
      if (Q !== expect_q) begin
        tests_failed++;
        $display("FAIL rand_edge iter=%0d: Q=%b expected=%b", n, Q, expect_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_preset();
    test_reset_mid_count();
    test_both_low();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
